// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subs_serial_if.sv
// Handshake bundle for the bit-serial subtractor.
// OVF is present only with GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN.
interface gf180mcu_fd_sc_mcu7t5v0__subs_serial_if;
  logic IN_VALID;
  logic IN_READY;
  logic A;
  logic B;
  logic BI;
  logic OUT_VALID;
  logic OUT_READY;
  logic D;
  logic LAST;
  logic BO;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
  logic OVF;
`endif

  modport master (
    output IN_VALID, A, B, BI, OUT_READY,
    input  IN_READY, OUT_VALID, D, LAST, BO
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
    , input OVF
`endif
  );

  modport slave (
    input  IN_VALID, A, B, BI, OUT_READY,
    output IN_READY, OUT_VALID, D, LAST, BO
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
    , output OVF
`endif
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subs_serial.sv
// LSB-first bit-serial subtractor with a one-entry output register.
// Optional OVF output: define GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN.
module gf180mcu_fd_sc_mcu7t5v0__subs_serial #(
  parameter int WIDTH = 8
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__subs_serial_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic          out_valid_q, out_valid_d;
  logic          d_q, d_d;
  logic          last_q, last_d;
  logic          bo_q, bo_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic in_ready;
  logic in_xfer;
  logic bw;
  logic bw_next;
  logic is_msb;

  assign in_ready = !out_valid_q || bus.OUT_READY;
  assign in_xfer  = bus.IN_VALID && in_ready;

  // BI only enters the chain on bit 0 of a word
  assign bw      = (state_q == IDLE) ? bus.BI : borrow_q;
  assign bw_next = (~bus.A & bus.B) | (~(bus.A ^ bus.B) & bw);
  assign is_msb  = (idx_q == IW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    last_d      = last_q;
    bo_d        = bo_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_xfer) begin
      out_valid_d = 1'b1;
      d_d         = bus.A ^ bus.B ^ bw;
      last_d      = is_msb;
      bo_d        = is_msb ? bw_next : 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
      ovf_d       = is_msb ? (bw ^ bw_next) : 1'b0;
`endif
      borrow_d    = bw_next;
      if (is_msb) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = RUN;
      end
    end else if (bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
      d_q         <= 1'b0;
      last_q      <= 1'b0;
      bo_q        <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      last_q      <= last_d;
      bo_q        <= bo_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.D         = d_q;
  assign bus.LAST      = last_q;
  assign bus.BO        = bo_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
  assign bus.OVF       = ovf_q;
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__subs_serial.sv
// Bench: word-level arithmetic model vs. the bit-serial subtractor,
// with random input gaps, output stalls and a mid-word reset.
module tb_gf180mcu_fd_sc_mcu7t5v0__subs_serial;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__subs_serial_if bus();

  gf180mcu_fd_sc_mcu7t5v0__subs_serial #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
  } word_t;

  typedef struct {
    logic d;
    logic last;
    logic bo;
    logic ovf;
  } exp_t;

  word_t wq[$];
  exp_t  eq[$];
  int    bitn;
  logic  exp_ov;
  int    force_stall;
  int    n_vec;
  int    n_bad;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-word arithmetic, then split into the expected bit stream
  function automatic void push_expect(input word_t w);
    longint    diff;
    logic [63:0] dv;
    int        sa, sb, sd;
    logic      bo, ovf;
    exp_t      e;
    diff = longint'(w.a) - longint'(w.b) - longint'(w.bi);
    dv   = diff;
    bo   = diff < 0;
    sa   = w.a[W-1] ? int'(w.a) - (1 << W) : int'(w.a);
    sb   = w.b[W-1] ? int'(w.b) - (1 << W) : int'(w.b);
    sd   = sa - sb - int'(w.bi);
    ovf  = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    for (int i = 0; i < W; i++) begin
      e.d    = dv[i];
      e.last = (i == W-1);
      e.bo   = (i == W-1) ? bo : 1'b0;
      e.ovf  = (i == W-1) ? ovf : 1'b0;
      eq.push_back(e);
    end
  endfunction

  task automatic add_word(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi);
    word_t w;
    w.a = a;
    w.b = b;
    w.bi = bi;
    wq.push_back(w);
  endtask

  task automatic step(input int gap_pct, input int stall_pct);
    logic iv, ordy, ixfer, oxfer;
    exp_t e;
    @(negedge CLK);
    chk("out_valid", 32'(bus.OUT_VALID), 32'(exp_ov));
    if (force_stall > 0) begin
      ordy = 1'b0;
      force_stall--;
    end else begin
      ordy = ($urandom_range(99) >= stall_pct);
    end
    iv = (wq.size() > 0) && ($urandom_range(99) >= gap_pct);
    bus.OUT_READY = ordy;
    bus.IN_VALID  = iv;
    bus.A  = $urandom_range(1);
    bus.B  = $urandom_range(1);
    bus.BI = $urandom_range(1);
    if (iv) begin
      bus.A = wq[0].a[bitn];
      bus.B = wq[0].b[bitn];
      if (bitn == 0) bus.BI = wq[0].bi;
    end
    #1;
    chk("in_ready", 32'(bus.IN_READY), 32'(!exp_ov || ordy));
    oxfer = exp_ov && ordy;
    ixfer = iv && (!exp_ov || ordy);
    if (oxfer) begin
      if (eq.size() == 0) begin
        chk("spurious_out", 32'(1), 32'(0));
      end else begin
        e = eq.pop_front();
        chk("d", 32'(bus.D), 32'(e.d));
        chk("last", 32'(bus.LAST), 32'(e.last));
        chk("bo", 32'(bus.BO), 32'(e.bo));
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
        chk("ovf", 32'(bus.OVF), 32'(e.ovf));
`endif
      end
    end
    if (ixfer) begin
      if (bitn == 0) push_expect(wq[0]);
      bitn++;
      if (bitn == W) begin
        bitn = 0;
        void'(wq.pop_front());
      end
    end
    if (ixfer) exp_ov = 1'b1;
    else if (oxfer) exp_ov = 1'b0;
  endtask

  task automatic run(input int gap_pct, input int stall_pct);
    int budget;
    budget = 5000;
    while ((wq.size() > 0 || eq.size() > 0 || exp_ov) && budget > 0) begin
      step(gap_pct, stall_pct);
      budget--;
    end
    if (budget == 0) chk("timeout", 32'(1), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'(0));
    chk("rst_d", 32'(bus.D), 32'(0));
    chk("rst_last", 32'(bus.LAST), 32'(0));
    chk("rst_bo", 32'(bus.BO), 32'(0));
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBS_SERIAL_OVF_EN
    chk("rst_ovf", 32'(bus.OVF), 32'(0));
`endif
    RST = 1'b0;
    wq.delete();
    eq.delete();
    bitn = 0;
    exp_ov = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.IN_READY), 32'(1));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    bitn = 0;
    exp_ov = 1'b0;
    force_stall = 0;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.A = 1'b0;
    bus.B = 1'b0;
    bus.BI = 1'b0;
    repeat (2) @(negedge CLK);
    do_reset();

    // directed words, streaming with no gaps or stalls
    add_word(8'h05, 8'h03, 1'b0);
    add_word(8'h03, 8'h05, 1'b0);
    add_word(8'h05, 8'h03, 1'b1);
    add_word(8'h80, 8'h01, 1'b0);
    add_word(8'h10, 8'h01, 1'b0);
    run(0, 0);

    // 3-cycle output stall while bit 4 sits in the output register
    add_word(8'hA7, 8'h5C, 1'b1);
    while (bitn != 5) step(0, 0);
    force_stall = 3;
    run(0, 0);

    // reset after 3 accepted bits discards the partial word
    add_word(8'hFF, 8'h00, 1'b0);
    while (bitn != 3) step(0, 0);
    do_reset();
    add_word(8'h0A, 8'h0A, 1'b0);
    run(0, 0);

    // random words under random gaps and stalls
    for (int k = 0; k < 40; k++)
      add_word(W'($urandom), W'($urandom), 1'($urandom_range(1)));
    run(30, 30);
    for (int k = 0; k < 20; k++)
      add_word(W'($urandom), W'($urandom), 1'($urandom_range(1)));
    run(0, 0);
    for (int k = 0; k < 20; k++)
      add_word(W'($urandom), W'($urandom), 1'($urandom_range(1)));
    run(60, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
